// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Supports short locked bursts and suppresses writes to x0.
module regfile_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    input  logic                        hold_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [$clog2(NUM_REQ)-1:0]  sel_o,
    output logic                        we_o,
    output logic [ADDR_W-1:0]           waddr_o,
    output logic [DATA_W-1:0]           wdata_o,
    output logic                        busy_o
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] owner;
    logic [CNT_W-1:0] cnt;

    logic             keep;
    logic             found;
    logic             grant;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] win_next;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    always_comb begin
        keep = (state == LOCKED) && req_i[owner] && lock_i[owner]
               && (cnt < MAX_CNT);
        // On release the owner drops to lowest priority.
        base = (state == LOCKED) ? SEL_W'((int'(owner) + 1) % NUM_REQ) : ptr;
        found = 1'b0;
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(base) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win = SEL_W'(idx);
            end
        end
        win_next = SEL_W'((int'(win) + 1) % NUM_REQ);
        grant = rst_n && !hold_i && (keep || found);
        gidx = keep ? owner : win;
        gnt_o = grant ? (NUM_REQ'(1) << gidx) : '0;
        sel_o = grant ? gidx : '0;
        g_addr = addr_i[int'(gidx)*ADDR_W +: ADDR_W];
        g_data = data_i[int'(gidx)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARB;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else begin
            we_o <= 1'b0;
            if (!hold_i) begin
                if (keep) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    state <= ARB;
                    if (found) begin
                        ptr <= win_next;
                        if (lock_i[win] && (MAX_BURST > 1)) begin
                            state <= LOCKED;
                            owner <= win;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                if (grant) begin
                    waddr_o <= g_addr;
                    wdata_o <= g_data;
                    we_o    <= |g_addr;
                end
            end
        end
    end

    assign busy_o = (state == LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic            hold;
    logic [N-1:0]    gnt;
    logic [1:0]      sel;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            busy;

    regfile_write_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock),
        .addr_i(addr), .data_i(data), .hold_i(hold),
        .gnt_o(gnt), .sel_o(sel), .we_o(we), .waddr_o(waddr),
        .wdata_o(wdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model state
    int m_ptr, m_locked, m_owner, m_cnt;
    int m_we, m_waddr;
    logic [DW-1:0] m_wdata;
    int e_win, e_keep;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] a_of(int k);
        return addr[k*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] d_of(int k);
        return data[k*DW +: DW];
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0;
        m_we = 0; m_waddr = 0; m_wdata = '0;
    endtask

    // Decide this cycle's winner from the documented rules.
    task automatic model_eval();
        int start;
        e_win = -1;
        e_keep = 0;
        if (rst_n && !hold) begin
            if (m_locked != 0 && req[m_owner] && lock[m_owner]
                && m_cnt < MB) begin
                e_win = m_owner;
                e_keep = 1;
            end else begin
                start = (m_locked != 0) ? (m_owner + 1) % N : m_ptr;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (start + k) % N;
                    if (req[j]) begin
                        e_win = j;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_we = 0;
            if (!hold) begin
                if (e_keep != 0) begin
                    m_cnt++;
                end else begin
                    m_locked = 0;
                    if (e_win >= 0) begin
                        m_ptr = (e_win + 1) % N;
                        if (lock[e_win] && MB > 1) begin
                            m_locked = 1;
                            m_owner = e_win;
                            m_cnt = 1;
                        end
                    end
                end
                if (e_win >= 0) begin
                    m_waddr = int'(a_of(e_win));
                    m_wdata = d_of(e_win);
                    m_we = (m_waddr != 0) ? 1 : 0;
                end
            end
        end
    endtask

    // Inputs set just after a rising edge; outputs compared at the falling edge.
    task automatic apply(logic [N-1:0] r, logic [N-1:0] l, logic h, logic rn);
        logic [N-1:0] eg;
        req = r; lock = l; hold = h; rst_n = rn;
        @(negedge clk);
        model_eval();
        eg = (e_win >= 0) ? (N'(1) << e_win) : '0;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("sel", 64'(sel), 64'((e_win >= 0) ? e_win : 0));
        chk("onehot", 64'($onehot0(gnt)), 64'(1));
        chk("we", 64'(we), 64'(m_we));
        chk("waddr", 64'(waddr), 64'(m_waddr));
        chk("wdata", 64'(wdata), 64'(m_wdata));
        chk("busy", 64'(busy), 64'(m_locked));
    endtask

    task automatic adv();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_payload();
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW] = AW'(k + 1);
            data[k*DW +: DW] = 32'hA000_0000 + DW'(k);
        end
    endtask

    initial begin
        model_reset();
        set_default_payload();
        req = '0; lock = '0; hold = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;

        // Reset state
        apply(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("rst_gnt", 64'(gnt), 64'(0));
        adv();
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        adv();

        // Round-robin rotation over all four
        apply(4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("rr0", 64'(gnt), 64'(4'b0001));
        adv();
        apply(4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("rr1", 64'(gnt), 64'(4'b0010));
        chk("rr1_we", 64'(we), 64'(1));
        adv();
        apply(4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("rr2", 64'(gnt), 64'(4'b0100));
        adv();
        apply(4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("rr3", 64'(gnt), 64'(4'b1000));
        adv();
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("rr3_waddr", 64'(waddr), 64'(4));
        adv();

        // Pointer at 2 after granting source 1; wrap picks source 0
        apply(4'b0010, 4'b0000, 1'b0, 1'b1);
        adv();
        apply(4'b0011, 4'b0000, 1'b0, 1'b1);
        chk("wrap_gnt", 64'(gnt), 64'(4'b0001));
        chk("wrap_sel", 64'(sel), 64'(0));
        adv();
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("wrap_we", 64'(we), 64'(1));
        chk("wrap_wdata", 64'(wdata), 64'(32'hA000_0000));
        adv();

        // Locked burst on source 1
        for (int c = 0; c < 4; c++) begin
            apply(4'b0011, 4'b0010, 1'b0, 1'b1);
            chk("burst_gnt", 64'(gnt), 64'(4'b0010));
            if (c > 0) chk("burst_busy", 64'(busy), 64'(1));
            adv();
        end
        apply(4'b0011, 4'b0010, 1'b0, 1'b1);
        chk("release_gnt", 64'(gnt), 64'(4'b0001));
        adv();
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("release_busy", 64'(busy), 64'(0));
        adv();

        // Write to x0 is granted but suppressed
        addr[2*AW +: AW] = '0;
        data[2*DW +: DW] = 32'hDEAD_BEEF;
        apply(4'b0100, 4'b0000, 1'b0, 1'b1);
        chk("x0_gnt", 64'(gnt), 64'(4'b0100));
        adv();
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("x0_we", 64'(we), 64'(0));
        adv();
        set_default_payload();

        // Hold during a burst at cnt=2
        apply(4'b0010, 4'b0010, 1'b0, 1'b1);
        adv();
        apply(4'b0010, 4'b0010, 1'b0, 1'b1);
        adv();
        apply(4'b0010, 4'b0010, 1'b1, 1'b1);
        chk("hold_gnt", 64'(gnt), 64'(0));
        adv();
        apply(4'b0010, 4'b0010, 1'b1, 1'b1);
        chk("hold_we", 64'(we), 64'(0));
        chk("hold_busy", 64'(busy), 64'(1));
        adv();
        for (int c = 0; c < 2; c++) begin
            apply(4'b0010, 4'b0010, 1'b0, 1'b1);
            chk("resume_gnt", 64'(gnt), 64'(4'b0010));
            adv();
        end
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        adv();
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        adv();

        // Reset mid-burst on source 3
        apply(4'b1000, 4'b1000, 1'b0, 1'b1);
        adv();
        apply(4'b1000, 4'b1000, 1'b0, 1'b1);
        adv();
        apply(4'b1000, 4'b1000, 1'b0, 1'b0);
        chk("midrst_gnt", 64'(gnt), 64'(0));
        adv();
        apply(4'b1001, 4'b0000, 1'b0, 1'b1);
        chk("postrst_gnt", 64'(gnt), 64'(4'b0001));
        chk("postrst_busy", 64'(busy), 64'(0));
        chk("postrst_waddr", 64'(waddr), 64'(0));
        adv();

        // Random traffic
        lock = '0;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r, l;
            l = lock;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) l[k] = ~l[k];
                addr[k*AW +: AW] = ($urandom_range(0, 7) == 0) ?
                                   '0 : AW'($urandom);
                data[k*DW +: DW] = $urandom;
            end
            r = N'($urandom_range(0, 15));
            apply(r, l, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 99) != 0));
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the single register-file write port between up to four write sources (ALU writeback, load unit, CSR/PC+4 path, debug port). Each cycle it picks one requester, drives the select of the 32-bit write-data mux, returns a grant to the winner and presents a registered write (enable, address, data) to the register unit. It also supports short locked bursts and drops writes to x0 as RV32I requires.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- MAX_BURST, 4, maximum consecutive grants to one locked requester (≥1)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_i  in  NUM_REQ  write request per source; held until granted
- lock_i  in  NUM_REQ  request a burst; sampled with req_i
- addr_i  in  NUM_REQ*ADDR_W  flattened destination addresses, source k at [k*ADDR_W +: ADDR_W]
- data_i  in  NUM_REQ*DATA_W  flattened write data, source k at [k*DATA_W +: DATA_W]
- hold_i  in  1  stall: no grant this cycle
- gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as request
- sel_o  out  $clog2(NUM_REQ)  mux select, index of current winner, 0 when no grant
- we_o  out  1  registered write enable to register file
- waddr_o  out  ADDR_W  registered write address
- wdata_o  out  DATA_W  registered write data
- busy_o  out  1  1 while in LOCKED state

## Operation
- State: round-robin pointer ptr (index with highest priority), FSM {ARB, LOCKED}, owner index, burst counter cnt (1..MAX_BURST).
- ARB: winner = first k with req_i[k]=1 scanning ptr, ptr+1, … wrapping mod NUM_REQ. On grant: ptr ← winner+1 mod NUM_REQ. If lock_i[winner]=1 and MAX_BURST>1: state ← LOCKED, owner ← winner, cnt ← 1.
- LOCKED: if req_i[owner]=1 and lock_i[owner]=1 and cnt<MAX_BURST: grant owner, cnt ← cnt+1. Otherwise state ← ARB and the same cycle performs ARB arbitration with ptr=owner+1 (owner has lowest priority); no idle cycle on release.
- No requests: gnt_o=0, sel_o=0, ptr unchanged.
- hold_i=1: gnt_o=0, sel_o=0, ptr/state/cnt/owner frozen; next-cycle we_o=0.
- Write pipeline: on grant of k, next edge loads waddr_o ← addr_i[k], wdata_o ← data_i[k], we_o ← (addr_i[k]≠0). Grant to an address-0 write is still issued (requester retires) but we_o=0.
- Cycle with no grant: we_o ← 0; waddr_o/wdata_o hold previous value.
- gnt_o always one-hot or zero; never grants a requester with req_i=0.

## Timing
- Reset (rst_n=0 at an edge): ptr=0, state=ARB, cnt=0, owner=0, we_o=0, waddr_o=0, wdata_o=0, busy_o=0; gnt_o/sel_o=0 while rst_n=0. Reset mid-burst abandons the burst; first post-reset grant starts from index 0.
- Grant latency 0 (combinational from req_i/lock_i/hold_i and state); write latency 1 cycle after grant.
- Requester drops req_i the cycle after seeing gnt_o; req_i held high after grant counts as a new request.
- busy_o asserted from the cycle after the locking grant until the cycle after release.
- Simultaneous release and new lock request from another source: release processed, new source arbitrated per ptr, may lock in that same cycle.

## Test plan
- Reset then req_i=4'b1111 held 4 cycles, lock_i=0 -> gnt_o 0001,0010,0100,1000; we_o one cycle later each; ptr wraps to 0.
- ptr=2, req_i=4'b0011 -> gnt_o=0001, sel_o=0; next cycle waddr_o/wdata_o = source 0 values, we_o=1.
- Source 1 lock_i=1, req_i=4'b0011 held, MAX_BURST=4 -> gnt_o=0010 for 4 consecutive cycles, busy_o=1, then gnt_o=0001 on 5th cycle, busy_o=0.
- Source 2 writes addr 0, data 32'hDEADBEEF -> gnt_o=0100, next cycle we_o=0.
- hold_i=1 for 2 cycles during LOCKED at cnt=2 -> gnt_o=0, we_o=0, burst resumes at cnt=2 after hold drops.
- rst_n=0 for one cycle mid-burst on source 3 -> all outputs 0, next grant with req_i=4'b1000|0001 goes to source 0.
